nettlp_eth_rx: RTL and testbench

- Receive-side counterpart of the NetTLP Ethernet TX framer.
- Consumes the 64-bit AXI-Stream RX output of the 10G Ethernet subsystem. Parses the Ethernet, IPv4, UDP and NetTLP headers qword by qword (qwords 0-5, 48 bytes). Filters out non-NetTLP frames.
- Writes the encapsulated TLP beats into the PCIE_TX FIFO (78-bit PCIE_FIFO64_TX format) feeding the PCIe core.
- Also exports the NetTLP sequence number and timestamp of each accepted packet, plus drop statistics.

---
 rtl/nettlp_eth_rx_if.sv | 27 ++
 rtl/nettlp_eth_rx.sv | 226 ++++++++++++++++++++++
 tb/tb_nettlp_eth_rx.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nettlp_eth_rx_if.sv
// Ethernet RX stream and PCIE_TX FIFO write bundle for the NetTLP receive parser.
// Latency: none (wiring only).
// Backpressure: the RX stream has no tready; the FIFO side only reports prog_full.
interface nettlp_eth_rx_if;
  logic        eth_rx_tvalid;
  logic        eth_rx_tlast;
  logic [7:0]  eth_rx_tkeep;
  logic [63:0] eth_rx_tdata;
  logic        eth_rx_tuser;
  logic        fifo_prog_full;
  logic        fifo_wr_en;
  logic [77:0] fifo_din;

  // Environment side: MAC stream source and FIFO status.
  modport master (
    output eth_rx_tvalid, eth_rx_tlast, eth_rx_tkeep, eth_rx_tdata, eth_rx_tuser,
    output fifo_prog_full,
    input  fifo_wr_en, fifo_din
  );

  // Parser side.
  modport slave (
    input  eth_rx_tvalid, eth_rx_tlast, eth_rx_tkeep, eth_rx_tdata, eth_rx_tuser,
    input  fifo_prog_full,
    output fifo_wr_en, fifo_din
  );
endinterface

// File: rtl/nettlp_eth_rx.sv
// NetTLP RX parser: checks Eth/IPv4/UDP/NetTLP headers, forwards TLP beats to PCIE_TX FIFO.
// Latency: 1 clk156 from payload beat to fifo_wr_en; hdr_* one cycle after first payload beat.
// Backpressure: none possible; frames are dropped if prog_full at qword0. NETTLP_RX_CSUM_EN adds IPv4 checksum check.
module nettlp_eth_rx #(
  parameter logic [15:0] UDP_PORT_BASE = 16'h3000,
  parameter logic [15:0] UDP_PORT_MASK = 16'hF000,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk156,
  input  logic             eth_rst,
  input  logic [31:0]      local_ip,
  nettlp_eth_rx_if.slave   rx,
  output logic             hdr_valid,
  output logic [15:0]      hdr_seq,
  output logic [31:0]      hdr_tstamp,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             err_overflow
);

  typedef enum logic [2:0] {
    S_H0, S_H1, S_H2, S_H3, S_H4, S_H5, S_PAYLOAD, S_DROP
  } state_t;

  // prog_full guarantees room for one maximum TLP beyond its threshold.
  localparam logic [5:0] TLP_MAX_BEATS = 6'd34;

  state_t           state_q, state_d;
  logic             bad_q, bad_d;
  logic             first_q, first_d;
  logic [15:0]      daddr0_q, daddr0_d;
  logic [15:0]      seq_lat_q, seq_lat_d;
  logic [31:0]      ts_lat_q, ts_lat_d;
  logic             wr_en_q, wr_en_d;
  logic [77:0]      din_q, din_d;
  logic             hdr_valid_q, hdr_valid_d;
  logic [15:0]      hdr_seq_q, hdr_seq_d;
  logic [31:0]      hdr_tstamp_q, hdr_tstamp_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             ovf_q, ovf_d;
  logic [5:0]       room_q, room_d;

  logic [63:0]      beat_r;
  logic             chk_fail;
  logic             csum_bad;

  // Byte-reverse the beat so wire byte 0 sits in [63:56] (network order).
  always_comb begin
    beat_r = '0;
    for (int i = 0; i < 8; i++) begin
      beat_r[63-8*i -: 8] = rx.eth_rx_tdata[8*i +: 8];
    end
  end

`ifdef NETTLP_RX_CSUM_EN
  logic [15:0] csum_q, csum_d;
  logic [18:0] csum_raw;
  logic [16:0] csum_f1;
  logic [15:0] csum_f2;

  // One's-complement accumulation of the IPv4 header halfwords carried in qwords 1-4.
  always_comb begin
    csum_raw = {3'b0, csum_q};
    case (state_q)
      S_H1: csum_raw = {3'b0, csum_q} + {3'b0, beat_r[15:0]};
      S_H2, S_H3: csum_raw = {3'b0, csum_q} + {3'b0, beat_r[63:48]} + {3'b0, beat_r[47:32]}
                           + {3'b0, beat_r[31:16]} + {3'b0, beat_r[15:0]};
      S_H4: csum_raw = {3'b0, csum_q} + {3'b0, beat_r[63:48]};
      default: ;
    endcase
    csum_f1  = {1'b0, csum_raw[15:0]} + {14'b0, csum_raw[18:16]};
    csum_f2  = csum_f1[15:0] + {15'b0, csum_f1[16]};
    csum_d   = csum_q;
    if (rx.eth_rx_tvalid) begin
      csum_d = (state_q == S_H0) ? 16'h0000 : csum_f2;
    end
    csum_bad = (state_q == S_H4) && (csum_f2 != 16'hFFFF);
  end

  // Checksum accumulator register.
  always_ff @(posedge clk156 or posedge eth_rst) begin
    if (eth_rst) csum_q <= '0;
    else         csum_q <= csum_d;
  end
`else
  assign csum_bad = 1'b0;
`endif

  // Per-qword header checks on the byte-reversed beat.
  always_comb begin
    chk_fail = 1'b0;
    case (state_q)
      S_H1: chk_fail = (beat_r[31:16] != 16'h0800) || (beat_r[15:12] != 4'd4)
                    || (beat_r[11:8] != 4'd5);
      S_H2: chk_fail = (beat_r[7:0] != 8'h11) || (beat_r[29:16] != 14'd0);
      S_H4: chk_fail = ({daddr0_q, beat_r[63:48]} != local_ip)
                    || ((beat_r[31:16] & UDP_PORT_MASK) != UDP_PORT_BASE) || csum_bad;
      default: ;
    endcase
  end

  // Next-state, FIFO write, header export and statistics.
  always_comb begin
    state_d      = state_q;
    bad_d        = bad_q;
    first_d      = first_q;
    daddr0_d     = daddr0_q;
    seq_lat_d    = seq_lat_q;
    ts_lat_d     = ts_lat_q;
    wr_en_d      = 1'b0;
    din_d        = din_q;
    hdr_valid_d  = 1'b0;
    hdr_seq_d    = hdr_seq_q;
    hdr_tstamp_d = hdr_tstamp_q;
    pkt_cnt_d    = pkt_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    ovf_d        = ovf_q;
    room_d       = rx.fifo_prog_full ? room_q : 6'd0;

    if (rx.eth_rx_tvalid) begin
      case (state_q)
        S_H0: begin
          bad_d = 1'b0;
          if (rx.eth_rx_tlast || rx.fifo_prog_full) drop_cnt_d = drop_cnt_q + CNT_W'(1);
          if (rx.eth_rx_tlast)        state_d = S_H0;
          else if (rx.fifo_prog_full) state_d = S_DROP;
          else                        state_d = S_H1;
        end
        S_H1, S_H2, S_H3, S_H4: begin
          bad_d = bad_q | chk_fail;
          if (state_q == S_H3) daddr0_d = beat_r[15:0];
          if (rx.eth_rx_tlast) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
            state_d    = S_H0;
          end else begin
            state_d = state_t'(state_q + 3'd1);
          end
        end
        S_H5: begin
          seq_lat_d = beat_r[47:32];
          ts_lat_d  = beat_r[31:0];
          if (rx.eth_rx_tlast || bad_q) drop_cnt_d = drop_cnt_q + CNT_W'(1);
          if (rx.eth_rx_tlast) state_d = S_H0;
          else if (bad_q)      state_d = S_DROP;
          else begin
            state_d = S_PAYLOAD;
            first_d = 1'b1;
          end
        end
        S_PAYLOAD: begin
          wr_en_d = 1'b1;
          din_d   = {1'b1, rx.eth_rx_tlast, rx.eth_rx_tkeep, rx.eth_rx_tdata,
                     rx.eth_rx_tuser & rx.eth_rx_tlast, 3'b000};
          if (first_q) begin
            hdr_valid_d  = 1'b1;
            hdr_seq_d    = seq_lat_q;
            hdr_tstamp_d = ts_lat_q;
            first_d      = 1'b0;
          end
          // Writes beyond the guaranteed headroom while prog_full is up overflow the FIFO.
          if (rx.fifo_prog_full) begin
            if (room_q == TLP_MAX_BEATS) ovf_d  = 1'b1;
            else                         room_d = room_q + 6'd1;
          end
          if (rx.eth_rx_tlast) begin
            if (rx.eth_rx_tuser) drop_cnt_d = drop_cnt_q + CNT_W'(1);
            else                 pkt_cnt_d  = pkt_cnt_q + CNT_W'(1);
            state_d = S_H0;
          end
        end
        S_DROP: begin
          if (rx.eth_rx_tlast) state_d = S_H0;
        end
        default: state_d = S_H0;
      endcase
    end
  end

  // State and output registers; reset clears everything, including mid-frame.
  always_ff @(posedge clk156 or posedge eth_rst) begin
    if (eth_rst) begin
      state_q      <= S_H0;
      bad_q        <= 1'b0;
      first_q      <= 1'b0;
      daddr0_q     <= '0;
      seq_lat_q    <= '0;
      ts_lat_q     <= '0;
      wr_en_q      <= 1'b0;
      din_q        <= '0;
      hdr_valid_q  <= 1'b0;
      hdr_seq_q    <= '0;
      hdr_tstamp_q <= '0;
      pkt_cnt_q    <= '0;
      drop_cnt_q   <= '0;
      ovf_q        <= 1'b0;
      room_q       <= '0;
    end else begin
      state_q      <= state_d;
      bad_q        <= bad_d;
      first_q      <= first_d;
      daddr0_q     <= daddr0_d;
      seq_lat_q    <= seq_lat_d;
      ts_lat_q     <= ts_lat_d;
      wr_en_q      <= wr_en_d;
      din_q        <= din_d;
      hdr_valid_q  <= hdr_valid_d;
      hdr_seq_q    <= hdr_seq_d;
      hdr_tstamp_q <= hdr_tstamp_d;
      pkt_cnt_q    <= pkt_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      ovf_q        <= ovf_d;
      room_q       <= room_d;
    end
  end

  assign rx.fifo_wr_en = wr_en_q;
  assign rx.fifo_din   = din_q;
  assign hdr_valid     = hdr_valid_q;
  assign hdr_seq       = hdr_seq_q;
  assign hdr_tstamp    = hdr_tstamp_q;
  assign pkt_cnt       = pkt_cnt_q;
  assign drop_cnt      = drop_cnt_q;
  assign err_overflow  = ovf_q;

endmodule

// File: tb/tb_nettlp_eth_rx.sv
// Directed bench for nettlp_eth_rx: builds NetTLP frames byte by byte and scoreboards FIFO writes.
// Latency: checks the 1-cycle payload-to-write latency on the first TLP beat.
// Backpressure: exercises prog_full drop, overflow headroom and mid-frame reset.
module tb_nettlp_eth_rx;
`ifdef NETTLP_RX_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic        clk156 = 1'b0;
  logic        eth_rst = 1'b0;
  logic [31:0] local_ip;
  logic        hdr_valid;
  logic [15:0] hdr_seq;
  logic [31:0] hdr_tstamp;
  logic [31:0] pkt_cnt;
  logic [31:0] drop_cnt;
  logic        err_overflow;

  nettlp_eth_rx_if rx_if ();

  nettlp_eth_rx dut (
    .clk156       (clk156),
    .eth_rst      (eth_rst),
    .local_ip     (local_ip),
    .rx           (rx_if),
    .hdr_valid    (hdr_valid),
    .hdr_seq      (hdr_seq),
    .hdr_tstamp   (hdr_tstamp),
    .pkt_cnt      (pkt_cnt),
    .drop_cnt     (drop_cnt),
    .err_overflow (err_overflow)
  );

  always #5 clk156 = ~clk156;

  int checks = 0;
  int errors = 0;
  int ftag   = 0;
  int hv_cnt = 0;
  logic [15:0] hv_seq = '0;
  logic [31:0] hv_ts  = '0;
  logic [77:0] act_q[$];
  logic [77:0] exp_q[$];
  int exp_pkt  = 0;
  int exp_drop = 0;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Capture FIFO writes and header pulses away from the active edge.
  always @(negedge clk156) begin
    if (rx_if.fifo_wr_en) act_q.push_back(rx_if.fifo_din);
    if (hdr_valid) begin
      hv_cnt <= hv_cnt + 1;
      hv_seq <= hdr_seq;
      hv_ts  <= hdr_tstamp;
    end
  end

  task automatic idle(input int n);
    rx_if.eth_rx_tvalid = 1'b0;
    rx_if.eth_rx_tlast  = 1'b0;
    rx_if.eth_rx_tuser  = 1'b0;
    repeat (n) begin
      @(posedge clk156);
      @(negedge clk156);
    end
  endtask

  task automatic drive(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
    rx_if.eth_rx_tvalid = 1'b1;
    rx_if.eth_rx_tdata  = d;
    rx_if.eth_rx_tkeep  = k;
    rx_if.eth_rx_tlast  = l;
    rx_if.eth_rx_tuser  = u;
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwr"}, 80'(act_q.size()), 80'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      chk({tag, "_din"}, 80'(act_q[i]), 80'(exp_q[i]));
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic check_cnts(input string tag);
    chk({tag, "_pkt"}, 80'(pkt_cnt), 80'(exp_pkt));
    chk({tag, "_drop"}, 80'(drop_cnt), 80'(exp_drop));
  endtask

  // runt_q >= 0: tlast on that header qword. rst_at >= 0: reset on that payload beat.
  task automatic send_frame(input logic [15:0] etype, input logic [15:0] dport,
                            input logic [31:0] daddr, input logic [15:0] seq,
                            input logic [31:0] ts, input int npay, input logic [7:0] lkeep,
                            input logic tu, input logic [15:0] csum_xor, input int runt_q,
                            input int pf_from, input int rst_at, input bit exp_wr);
    logic [7:0]  b [48];
    logic [63:0] d;
    logic [15:0] cks;
    int unsigned s;
    logic        last;
    ftag++;
    foreach (b[i]) b[i] = 8'h00;
    b[0] = 8'h02; b[5] = 8'h01; b[6] = 8'h02; b[11] = 8'h02;
    {b[12], b[13]} = etype;
    b[14] = 8'h45;
    {b[16], b[17]} = 16'(34 + npay * 8);
    {b[18], b[19]} = 16'(ftag);
    {b[20], b[21]} = 16'h4000;
    b[22] = 8'd64;
    b[23] = 8'h11;
    {b[26], b[27], b[28], b[29]} = 32'hC0A8_0A03;
    {b[30], b[31], b[32], b[33]} = daddr;
    {b[34], b[35]} = 16'h3000;
    {b[36], b[37]} = dport;
    {b[38], b[39]} = 16'(14 + npay * 8);
    {b[42], b[43]} = seq;
    {b[44], b[45], b[46], b[47]} = ts;
    s = 0;
    for (int i = 14; i < 34; i += 2) s += 32'({b[i], b[i+1]});
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    cks = ~s[15:0] ^ csum_xor;
    {b[24], b[25]} = cks;

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 8; i++) d[8*i +: 8] = b[8*k + i];
      drive(d, 8'hFF, k == runt_q, 1'b0);
      @(posedge clk156);
      @(negedge clk156);
      if (k == runt_q) begin
        rx_if.eth_rx_tvalid = 1'b0;
        return;
      end
    end
    for (int j = 0; j < npay; j++) begin
      last = (j == npay - 1);
      d = {16'hDA7A, 16'(ftag), 16'(j), 16'hBEEF};
      if (j == pf_from) rx_if.fifo_prog_full = 1'b1;
      drive(d, last ? lkeep : 8'hFF, last, last & tu);
      if (j == rst_at) begin
        #2 eth_rst = 1'b1;
        #1;
        chk("rst_wr_en", 80'(rx_if.fifo_wr_en), 80'd0);
        chk("rst_pkt", 80'(pkt_cnt), 80'd0);
        chk("rst_drop", 80'(drop_cnt), 80'd0);
        chk("rst_ovf", 80'(err_overflow), 80'd0);
        chk("rst_seq", 80'(hdr_seq), 80'd0);
        rx_if.eth_rx_tvalid = 1'b0;
        @(negedge clk156);
        @(negedge clk156);
        eth_rst = 1'b0;
        act_q.delete();
        exp_q.delete();
        return;
      end
      if (exp_wr) exp_q.push_back({1'b1, last, last ? lkeep : 8'hFF, d, last & tu, 3'b000});
      @(posedge clk156);
      @(negedge clk156);
      if (j == 0 && exp_wr) chk("lat1", 80'(rx_if.fifo_wr_en), 80'd1);
      if (pf_from == 0 && j == 33) chk("ovf_pre", 80'(err_overflow), 80'd0);
    end
    rx_if.eth_rx_tvalid = 1'b0;
    rx_if.eth_rx_tlast  = 1'b0;
    rx_if.eth_rx_tuser  = 1'b0;
  endtask

  localparam logic [31:0] IP = 32'hC0A8_0A01;

  initial begin
    local_ip             = IP;
    rx_if.eth_rx_tvalid  = 1'b0;
    rx_if.eth_rx_tlast   = 1'b0;
    rx_if.eth_rx_tkeep   = 8'h00;
    rx_if.eth_rx_tdata   = '0;
    rx_if.eth_rx_tuser   = 1'b0;
    rx_if.fifo_prog_full = 1'b0;
    #1 eth_rst = 1'b1;
    #1;
    chk("reset_wr_en", 80'(rx_if.fifo_wr_en), 80'd0);
    chk("reset_hdr_valid", 80'(hdr_valid), 80'd0);
    chk("reset_ovf", 80'(err_overflow), 80'd0);
    check_cnts("reset");
    repeat (3) @(negedge clk156);
    eth_rst = 1'b0;
    idle(2);

    // Valid frame, 3 TLP beats, short last beat.
    send_frame(16'h0800, 16'h3000, IP, 16'h0005, 32'hDEADBEEF, 3, 8'h0F, 1'b0, 16'h0, -1, -1, -1, 1'b1);
    idle(2);
    exp_pkt = 1;
    check_writes("t1");
    check_cnts("t1");
    chk("t1_hv_cnt", 80'(hv_cnt), 80'd1);
    chk("t1_seq", 80'(hv_seq), 80'h0005);
    chk("t1_ts", 80'(hv_ts), 80'hDEADBEEF);

    // Header filters: ethertype, UDP port, destination IP.
    send_frame(16'h86DD, 16'h3000, IP, 16'h0001, 32'h1, 3, 8'hFF, 1'b0, 16'h0, -1, -1, -1, 1'b0);
    send_frame(16'h0800, 16'h4000, IP, 16'h0002, 32'h2, 3, 8'hFF, 1'b0, 16'h0, -1, -1, -1, 1'b0);
    send_frame(16'h0800, 16'h3000, 32'hC0A8_0A02, 16'h0003, 32'h3, 3, 8'hFF, 1'b0, 16'h0, -1, -1, -1, 1'b0);
    idle(2);
    exp_drop = 3;
    check_writes("t2");
    check_cnts("t2");
    chk("t2_hv_cnt", 80'(hv_cnt), 80'd1);

    // 40-byte runt, then a valid frame back-to-back (masked port 0x3123).
    send_frame(16'h0800, 16'h3000, IP, 16'h0009, 32'h9, 0, 8'hFF, 1'b0, 16'h0, 4, -1, -1, 1'b0);
    send_frame(16'h0800, 16'h3123, IP, 16'h0007, 32'h12345678, 2, 8'hFF, 1'b0, 16'h0, -1, -1, -1, 1'b1);
    idle(2);
    exp_drop = 4; exp_pkt = 2;
    check_writes("t3");
    check_cnts("t3");
    chk("t3_seq", 80'(hv_seq), 80'h0007);
    chk("t3_ts", 80'(hv_ts), 80'h12345678);

    // MAC-errored frame: forwarded with src_dsc, counted as a drop.
    send_frame(16'h0800, 16'h3000, IP, 16'h000A, 32'hA, 2, 8'h03, 1'b1, 16'h0, -1, -1, -1, 1'b1);
    idle(2);
    exp_drop = 5;
    check_writes("t4");
    check_cnts("t4");
    chk("t4_hv_cnt", 80'(hv_cnt), 80'd3);

    // prog_full at qword0 drops the whole frame; next frame accepted.
    rx_if.fifo_prog_full = 1'b1;
    send_frame(16'h0800, 16'h3000, IP, 16'h000B, 32'hB, 3, 8'hFF, 1'b0, 16'h0, -1, -1, -1, 1'b0);
    rx_if.fifo_prog_full = 1'b0;
    send_frame(16'h0800, 16'h3000, IP, 16'h000C, 32'hC, 1, 8'h01, 1'b0, 16'h0, -1, -1, -1, 1'b1);
    idle(2);
    exp_drop = 6; exp_pkt = 3;
    check_writes("t5");
    check_cnts("t5");
    chk("t5_seq", 80'(hv_seq), 80'h000C);

    // Header checksum off by one, then a correct one.
    send_frame(16'h0800, 16'h3000, IP, 16'h000D, 32'hD, 2, 8'hFF, 1'b0, 16'h0001, -1, -1, -1, !CSUM_EN);
    send_frame(16'h0800, 16'h3000, IP, 16'h000E, 32'hE, 2, 8'hFF, 1'b0, 16'h0, -1, -1, -1, 1'b1);
    idle(2);
    if (CSUM_EN) begin exp_drop = 7; exp_pkt = 4; end
    else         begin exp_drop = 6; exp_pkt = 5; end
    check_writes("t6");
    check_cnts("t6");
    chk("t6_seq", 80'(hv_seq), 80'h000E);

    // prog_full rises on payload: 34 beats of headroom, the 35th overflows.
    send_frame(16'h0800, 16'h3000, IP, 16'h000F, 32'hF, 36, 8'hFF, 1'b0, 16'h0, -1, 0, -1, 1'b1);
    rx_if.fifo_prog_full = 1'b0;
    idle(2);
    exp_pkt = exp_pkt + 1;
    check_writes("t7");
    check_cnts("t7");
    chk("t7_ovf", 80'(err_overflow), 80'd1);

    // Reset on the second payload beat, then a clean frame.
    send_frame(16'h0800, 16'h3000, IP, 16'h0010, 32'h10, 4, 8'hFF, 1'b0, 16'h0, -1, -1, 1, 1'b1);
    send_frame(16'h0800, 16'h3000, IP, 16'h0011, 32'hCAFEF00D, 2, 8'h7F, 1'b0, 16'h0, -1, -1, -1, 1'b1);
    idle(2);
    exp_pkt = 1; exp_drop = 0;
    check_writes("t8");
    check_cnts("t8");
    chk("t8_seq", 80'(hv_seq), 80'h0011);
    chk("t8_ts", 80'(hv_ts), 80'hCAFEF00D);
    chk("t8_ovf", 80'(err_overflow), 80'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog: the directed sequence is a few hundred cycles.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
